// File: rtl/fsb_node_egress_buffer.sv
// Elastic FIFO between the node FSB output (valid/yumi) and the FSB ring (valid/ready); optional bypass via FSB_EGRESS_BYPASS_EN.
// Latency: 1 cycle through storage; 0 cycles on the bypass path when FSB_EGRESS_BYPASS_EN is defined and the FIFO is empty.
// Backpressure: ring stalls fill the FIFO; yumi_o drops while full (no full-cycle pass-through) or while en_i is low.
module fsb_node_egress_buffer #(
    parameter int ring_width_p = 80,
    parameter int els_p        = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        en_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        yumi_o,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        ready_i,
    output logic [$clog2(els_p+1)-1:0]  count_o,
    output logic [15:0]                 stall_cnt_o
);

    localparam int aw_lp = $clog2(els_p);
    localparam int cw_lp = $clog2(els_p + 1);
    localparam logic [cw_lp-1:0] full_cnt_lp = cw_lp'(els_p);

    // Entry storage is deliberately not reset; validity is tracked by count_q.
    logic [ring_width_p-1:0] mem_q [els_p];

    logic [aw_lp-1:0] wp_q, wp_d;
    logic [aw_lp-1:0] rp_q, rp_d;
    logic [cw_lp-1:0] count_q, count_d;
    logic [15:0]      stall_q, stall_d;

    logic empty, full;
    logic wr_en;   // packet goes into storage
    logic rd_en;   // stored packet leaves storage

    assign empty = (count_q == '0);
    assign full  = (count_q == full_cnt_lp);

    // reset_n_i in the product keeps yumi_o low while reset is held, while
    // v_i -> yumi_o remains a single gate against registered state.
    assign yumi_o = v_i & en_i & reset_n_i & ~full;

`ifdef FSB_EGRESS_BYPASS_EN
    logic bypass;
    // An empty FIFO lets the node packet straight through to the ring.
    assign bypass = empty & v_i & en_i & reset_n_i;
    assign v_o    = ~empty | bypass;
    assign data_o = bypass ? data_i : mem_q[rp_q];
    // A bypassed packet taken by the ring never touches storage.
    assign wr_en  = yumi_o & ~(bypass & ready_i);
    assign rd_en  = ~empty & ready_i;
`else
    assign v_o    = ~empty;
    assign data_o = mem_q[rp_q];
    assign wr_en  = yumi_o;
    assign rd_en  = v_o & ready_i;
`endif

    assign count_o     = count_q;
    assign stall_cnt_o = stall_q;

    // Next-state for pointers, occupancy and the saturating stall counter.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        stall_d = stall_q;
        if (wr_en) begin
            wp_d = wp_q + aw_lp'(1);
        end
        if (rd_en) begin
            rp_d = rp_q + aw_lp'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + cw_lp'(1);
        end else if (!wr_en && rd_en) begin
            count_d = count_q - cw_lp'(1);
        end
        if (v_o && !ready_i && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Control state; reset discards anything buffered.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Entry write at the write pointer on every stored accept.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wp_q] <= data_i;
        end
    end

endmodule

// File: doc/fsb_node_egress_buffer.md
# fsb_node_egress_buffer

Elastic buffer between the mesh node's FSB output channel and the FSB ring. It drains packets from the node using the node's valid/yumi protocol and presents them to the ring with a valid/ready handshake. This decouples the node's late yumi from ring backpressure. It also exposes occupancy and a ring-stall statistic for debug.

## Interface

**Parameters**
- `ring_width_p`, default 80: FSB packet width (destid + cmd + client data).
- `els_p`, default 4: FIFO depth in packets; must be a power of two, ≥ 2.

**Ports**
- `clk_i`, input, 1: sole clock.
- `reset_n_i`, input, 1: reset, asynchronous assert, active-low.
- `en_i`, input, 1: accept enable; when low, no new packets are taken from the node.
- `v_i`, input, 1: node has a packet.
- `data_i`, input, `ring_width_p`: node packet.
- `yumi_o`, output, 1: packet consumed this cycle; combinational from `v_i`, `en_i` and occupancy.
- `v_o`, output, 1: packet available to the ring.
- `data_o`, output, `ring_width_p`: packet to the ring.
- `ready_i`, input, 1: ring accepts `data_o` this cycle.
- `count_o`, output, `$clog2(els_p+1)`: current occupancy, 0..`els_p`.
- `stall_cnt_o`, output, 16: saturating count of cycles with `v_o & ~ready_i`.

## Operation

- **Storage:** circular FIFO of `els_p` entries, addressed by write pointer `wp` and read pointer `rp`, each `$clog2(els_p)` bits, wrapping modulo `els_p`. The entry array itself is not reset.
- **Accept:** `yumi_o = v_i & en_i & (count != els_p)`.
  - `yumi_o` is never asserted without `v_i`.
  - On `yumi_o`, `data_i` is written at `wp` and `wp` increments.
- **Present:** `v_o = (count != 0)` and `data_o = mem[rp]`.
  - On `v_o & ready_i`, `rp` increments.
- **Count update:** `count` increments on accept only, decrements on dequeue only, and is unchanged when both or neither occur.
- **Full:** `yumi_o` = 0 even if a dequeue happens the same cycle. There is no full-cycle pass-through.
- **Empty:** `v_o` = 0; `data_o` is don't-care. An enqueue into an empty FIFO is visible the next cycle.
- **`en_i` low:** draining continues normally; only acceptance is blocked. `en_i` may toggle on any cycle.
- **`stall_cnt_o`:** increments by 1 on every cycle with `v_o & ~ready_i`, saturates at 16'hFFFF, and clears only on reset.
- **Reset asserted (any time, including mid-transfer):**
  - `wp`, `rp` and `count` go to 0; `v_o` = 0, `yumi_o` = 0, `stall_cnt_o` = 0.
  - Buffered packets are discarded.
  - The first rising edge after deassertion is a normal cycle.

## Timing

- Without the bypass feature, latency is 1 cycle: a packet accepted at edge t has `v_o` = 1 in cycle t+1.
- Sustained throughput is 1 packet/cycle when `ready_i` stays high.
- Output reset values: `v_o` = 0, `count_o` = 0, `stall_cnt_o` = 0, `yumi_o` = 0, `data_o` = X.
- Ring handshake rule: once `v_o` is asserted, `data_o` is held stable until `ready_i` is sampled high.
- `yumi_o` must settle within the same cycle as `v_i`. The path from `v_i` to `yumi_o` is a single AND gate with registered state.

## Configuration

- **`FSB_EGRESS_BYPASS_EN` defined:**
  - When `count == 0` and `v_i & en_i`, then `v_o` = 1 and `data_o = data_i` combinationally.
  - If `ready_i` is also high, the packet is consumed (`yumi_o` = 1) and is not written to the FIFO. Latency is 0 cycles.
  - If `ready_i` is low, the packet is written to the FIFO as normal.
  - A combinational `v_i`-to-`v_o` path exists only in this mode.
- **`FSB_EGRESS_BYPASS_EN` undefined:** all packets pass through storage; latency is 1 cycle; `v_o` is a function of registered state only.

## Test plan

- **Reset and basic transfer:** hold reset low with `v_i` = 1 → `yumi_o` = 0, `v_o` = 0, `count_o` = 0. Release reset, send 0x1…A5 with `ready_i` = 1 → `data_o` = 0x1…A5 with `v_o` = 1 one cycle later (0 cycles with bypass); `count_o` returns to 0.
- **Fill and full:** with `els_p` = 4 and `ready_i` = 0, send 6 packets → `yumi_o` high for the first 4 only; `count_o` = 4; `stall_cnt_o` increments every cycle once `v_o` = 1. Then raise `ready_i` → packets 1..4 emerge in order, one per cycle.
- **Simultaneous enqueue/dequeue:** at `count` = 2 with both enqueue and dequeue → `count_o` stays 2. At `count` = 4 with `ready_i` = 1 and `v_i` = 1 → `yumi_o` = 0 and `count_o` becomes 3.
- **Pointer wrap:** stream 100 sequentially numbered packets with random `ready_i` → output sequence is identical and no packet is lost or duplicated.
- **`en_i` gating:** `en_i` = 0 with 3 packets buffered → `yumi_o` = 0 while all 3 drain. Re-raise `en_i` → acceptance resumes the next cycle.
- **Reset mid-operation:** assert `reset_n_i` low between clock edges while holding 3 packets → `v_o`, `count_o` and `stall_cnt_o` drop to 0 immediately. After release, a new packet emerges as the first output.
